// File: rtl/uart_host_pkg.sv
// Shared definitions for the UART host bridge: FSM states, register map,
// interrupt source codes and the acknowledge-data helper.
package uart_host_pkg;

    // Bridge FSM states
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SETUP      = 3'd1;
    localparam logic [2:0] ST_STROBE     = 3'd2;
    localparam logic [2:0] ST_CAPTURE    = 3'd3;
    localparam logic [2:0] ST_ACK_SETUP  = 3'd4;
    localparam logic [2:0] ST_ACK_STROBE = 3'd5;
    localparam logic [2:0] ST_ACK_DONE   = 3'd6;

    // Component register map
    localparam logic [2:0] REG_CTL     = 3'd0;
    localparam logic [2:0] REG_RX_DATA = 3'd1;
    localparam logic [2:0] REG_TX_DATA = 3'd2;

    // Component interrupt sources
    localparam logic [2:0] IRQ_RX_AVAIL = 3'd1;
    localparam logic [2:0] IRQ_TX_DONE  = 3'd2;

    typedef enum logic [1:0] {
        IRQ_KIND_RX,
        IRQ_KIND_TX,
        IRQ_KIND_OTHER
    } irq_kind_t;

    // Classify an interrupt source code
    function automatic irq_kind_t decode_irq(input logic [2:0] id);
        case (id)
            IRQ_RX_AVAIL: return IRQ_KIND_RX;
            IRQ_TX_DONE:  return IRQ_KIND_TX;
            default:      return IRQ_KIND_OTHER;
        endcase
    endfunction

    // Data written to CTL to acknowledge source `id`
    function automatic logic [7:0] ack_data(input logic [7:0] ack_bit, input logic [2:0] id);
        return ack_bit | {5'b0, id};
    endfunction

endpackage

// File: rtl/uart_host_bridge_if.sv
// Strobe bus between the host bridge (master) and the UART component (slave).
interface uart_host_bridge_if;
    logic       cs;
    logic       rd;
    logic       wr;
    logic [2:0] addr;
    logic [7:0] in_data;
    logic [7:0] out_data;
    logic       irq;
    logic [2:0] irq_id;

    modport master (output cs, rd, wr, addr, in_data, input out_data, irq, irq_id);
    modport slave  (input cs, rd, wr, addr, in_data, output out_data, irq, irq_id);
endinterface

// File: rtl/uart_host_fifo.sv
// Byte FIFO for received data; DEPTH must be a power of two so the
// pointers wrap naturally. A push while full succeeds if a pop happens
// in the same cycle.
module uart_host_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy tracking
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_host_bridge.sv
// Host-side bridge to a strobe-bus UART component: services component
// interrupts (RX read, TX-done, other) with a CTL acknowledge write and
// forwards host TX bytes as TX_DATA writes.
// Build option: UART_HOST_RX_FIFO_EN selects an RX_DEPTH-entry receive FIFO;
// without it received bytes go to a single holding register.
module uart_host_bridge
    import uart_host_pkg::*;
#(
    parameter int unsigned RX_DEPTH = 4,
    parameter logic [7:0]  ACK_BIT  = 8'h80
) (
    input  logic               clock,
    input  logic               reset,
    uart_host_bridge_if.master bus,
    output logic               rx_valid,
    output logic [7:0]         rx_byte,
    input  logic               rx_ready,
    input  logic               tx_valid,
    input  logic [7:0]         tx_byte,
    output logic               tx_ready,
    output logic               rx_overrun
);
    if (RX_DEPTH < 2 || RX_DEPTH > 16 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_host_bridge: RX_DEPTH must be a power of two in 2..16");
    end

    logic [2:0] state, state_d;
    logic       op_rd, op_rd_d;
    logic [2:0] id_q, id_d;
    logic       tx_busy, tx_busy_d;
    logic       overrun_d;
    logic [2:0] addr_d;
    logic [7:0] data_d;
    logic       cs_d, rd_d, wr_d;
    logic [7:0] rx_data_q;
    logic       push_c;
    logic       rx_pop_c;
    logic       rx_full_c;
    irq_kind_t  kind_c;

    assign kind_c   = decode_irq(bus.irq_id);
    assign rx_pop_c = rx_valid && rx_ready;
    // Combinational so a same-cycle irq always wins over a host transfer
    assign tx_ready = reset && (state == ST_IDLE) && !bus.irq && !tx_busy;

    // Next-state and next-output decode
    always_comb begin
        state_d   = state;
        op_rd_d   = op_rd;
        id_d      = id_q;
        tx_busy_d = tx_busy;
        overrun_d = rx_overrun;
        addr_d    = bus.addr;
        data_d    = bus.in_data;
        push_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.irq) begin
                    if (kind_c == IRQ_KIND_RX) begin
                        if (rx_full_c) begin
                            overrun_d = 1'b1;
                        end else begin
                            state_d = ST_SETUP;
                            op_rd_d = 1'b1;
                            id_d    = bus.irq_id;
                            addr_d  = REG_RX_DATA;
                        end
                    end else begin
                        state_d = ST_ACK_SETUP;
                        id_d    = bus.irq_id;
                        addr_d  = REG_CTL;
                        data_d  = ack_data(ACK_BIT, bus.irq_id);
                        if (kind_c == IRQ_KIND_TX) tx_busy_d = 1'b0;
                    end
                end else if (tx_valid && tx_ready) begin
                    state_d   = ST_SETUP;
                    op_rd_d   = 1'b0;
                    addr_d    = REG_TX_DATA;
                    data_d    = tx_byte;
                    tx_busy_d = 1'b1;
                end
            end
            ST_SETUP:      state_d = ST_STROBE;
            ST_STROBE:     state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                push_c = op_rd;
                if (op_rd) begin
                    state_d = ST_ACK_SETUP;
                    addr_d  = REG_CTL;
                    data_d  = ack_data(ACK_BIT, id_q);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK_SETUP:  state_d = ST_ACK_STROBE;
            ST_ACK_STROBE: state_d = ST_ACK_DONE;
            ST_ACK_DONE:   state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
        cs_d = !(state_d == ST_SETUP || state_d == ST_STROBE ||
                 state_d == ST_ACK_SETUP || state_d == ST_ACK_STROBE);
        rd_d = !(state_d == ST_STROBE && op_rd_d);
        wr_d = !((state_d == ST_STROBE && !op_rd_d) || state_d == ST_ACK_STROBE);
    end

    // FSM state and control registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            op_rd      <= 1'b0;
            id_q       <= 3'd0;
            tx_busy    <= 1'b0;
            rx_overrun <= 1'b0;
            rx_data_q  <= 8'd0;
        end else begin
            state      <= state_d;
            op_rd      <= op_rd_d;
            id_q       <= id_d;
            tx_busy    <= tx_busy_d;
            rx_overrun <= overrun_d;
            if (state == ST_STROBE && op_rd) rx_data_q <= bus.out_data;
        end
    end

    // Registered bus outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.cs      <= 1'b1;
            bus.rd      <= 1'b1;
            bus.wr      <= 1'b1;
            bus.addr    <= 3'd0;
            bus.in_data <= 8'd0;
        end else begin
            bus.cs      <= cs_d;
            bus.rd      <= rd_d;
            bus.wr      <= wr_d;
            bus.addr    <= addr_d;
            bus.in_data <= data_d;
        end
    end

`ifdef UART_HOST_RX_FIFO_EN
    logic fifo_empty;

    uart_host_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_c),
        .pop   (rx_pop_c),
        .din   (rx_data_q),
        .dout  (rx_byte),
        .empty (fifo_empty),
        .full  (rx_full_c)
    );

    assign rx_valid = !fifo_empty;
`else
    logic       hold_valid;
    logic [7:0] hold_data;

    // Single-entry receive holding register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_valid <= 1'b0;
            hold_data  <= 8'd0;
        end else if (push_c) begin
            hold_valid <= 1'b1;
            hold_data  <= rx_data_q;
        end else if (rx_pop_c) begin
            hold_valid <= 1'b0;
        end
    end

    assign rx_full_c = hold_valid;
    assign rx_valid  = hold_valid;
    assign rx_byte   = hold_data;
`endif

endmodule

// File: tb/tb_uart_host_bridge.sv
// Directed bench for uart_host_bridge: plays the UART component on the
// strobe bus and the host on the rx/tx streams.
module tb_uart_host_bridge;
    import uart_host_pkg::*;

    localparam int unsigned RX_DEPTH = 4;
`ifdef UART_HOST_RX_FIFO_EN
    localparam int RX_CAP = 4;
`else
    localparam int RX_CAP = 1;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_ready = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_byte = 8'd0;
    logic       tx_ready;
    logic       rx_overrun;

    int checks = 0;
    int errors = 0;
    int rd_count = 0;
    logic both_low = 1'b0;

    uart_host_bridge_if bus ();

    uart_host_bridge #(.RX_DEPTH(RX_DEPTH), .ACK_BIT(8'h80)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .rx_ready   (rx_ready),
        .tx_valid   (tx_valid),
        .tx_byte    (tx_byte),
        .tx_ready   (tx_ready),
        .rx_overrun (rx_overrun)
    );

    always #5 clock = ~clock;

    // Bus monitor: read strobe count and illegal double strobe
    always @(negedge clock) begin
        if (!bus.rd && !bus.wr) both_low <= 1'b1;
        if (!bus.cs && !bus.rd) rd_count <= rd_count + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // Wait (bounded) for the next rd or wr strobe; sample on the falling edge
    task automatic wait_strobe(output logic is_rd, output logic [2:0] a, output logic [7:0] d, output logic timeout);
        timeout = 1'b1; is_rd = 1'b0; a = 3'd0; d = 8'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (!bus.cs && (!bus.rd || !bus.wr)) begin
                is_rd = !bus.rd; a = bus.addr; d = bus.in_data; timeout = 1'b0;
                break;
            end
        end
    endtask

    // Host takes one byte from the receive stream
    task automatic pop_one(output logic v, output logic [7:0] b);
        v = rx_valid; b = rx_byte;
        rx_ready = 1'b1;
        @(negedge clock);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.irq = 1'b0; bus.irq_id = 3'd0; bus.out_data = 8'd0;
        repeat (3) @(negedge clock);
        checks++; if (bus.cs !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b expected 1", bus.cs); end
        checks++; if (bus.rd !== 1'b1 || bus.wr !== 1'b1) begin errors++; $display("FAIL reset_strobes: got rd=%b wr=%b expected 1/1", bus.rd, bus.wr); end
        checks++; if (bus.addr !== 3'd0 || bus.in_data !== 8'd0) begin errors++; $display("FAIL reset_addr_data: got %0d/%h expected 0/00", bus.addr, bus.in_data); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready: got %b expected 0", tx_ready); end
        checks++; if (rx_valid !== 1'b0 || rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_rx: got valid=%b ovr=%b expected 0/0", rx_valid, rx_overrun); end
        reset = 1'b1;
        @(negedge clock);
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL post_reset_tx_ready: got %b expected 1", tx_ready); end
    endtask

    task automatic test_tx_write();
        logic is_rd; logic [2:0] a; logic [7:0] d; logic to;
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL tx_idle_ready: got %b expected 1", tx_ready); end
        tx_byte = 8'hA5; tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        checks++; if (bus.cs !== 1'b0 || bus.addr !== REG_TX_DATA || bus.wr !== 1'b1) begin errors++; $display("FAIL tx_setup: got cs=%b addr=%0d wr=%b expected 0/2/1", bus.cs, bus.addr, bus.wr); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL tx_busy_ready: got %b expected 0", tx_ready); end
        @(negedge clock);
        checks++; if (bus.wr !== 1'b0 || bus.rd !== 1'b1 || bus.cs !== 1'b0) begin errors++; $display("FAIL tx_strobe: got cs=%b rd=%b wr=%b expected 0/1/0", bus.cs, bus.rd, bus.wr); end
        checks++; if (bus.addr !== 3'd2 || bus.in_data !== 8'hA5) begin errors++; $display("FAIL tx_strobe_data: got %0d/%h expected 2/a5", bus.addr, bus.in_data); end
        @(negedge clock);
        checks++; if (bus.cs !== 1'b1 || bus.wr !== 1'b1) begin errors++; $display("FAIL tx_capture: got cs=%b wr=%b expected 1/1", bus.cs, bus.wr); end
        @(negedge clock);
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL tx_wait_done: got %b expected 0", tx_ready); end
        bus.irq_id = IRQ_TX_DONE; bus.irq = 1'b1;
        wait_strobe(is_rd, a, d, to);
        bus.irq = 1'b0;
        checks++; if (to !== 1'b0 || is_rd !== 1'b0 || a !== 3'd0 || d !== 8'h82) begin errors++; $display("FAIL tx_done_ack: got to=%b rd=%b addr=%0d data=%h expected 0/0/0/82", to, is_rd, a, d); end
        repeat (2) @(negedge clock);
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL tx_ready_after_done: got %b expected 1", tx_ready); end
    endtask

    task automatic test_rx_read();
        logic is_rd; logic [2:0] a; logic [7:0] d; logic to; logic v; logic [7:0] b;
        rx_ready = 1'b0;
        bus.out_data = 8'h3C; bus.irq_id = IRQ_RX_AVAIL; bus.irq = 1'b1;
        wait_strobe(is_rd, a, d, to);
        checks++; if (to !== 1'b0 || is_rd !== 1'b1 || a !== 3'd1 || bus.wr !== 1'b1) begin errors++; $display("FAIL rx_read: got to=%b rd=%b addr=%0d wr=%b expected 0/1/1/1", to, is_rd, a, bus.wr); end
        wait_strobe(is_rd, a, d, to);
        bus.irq = 1'b0; bus.out_data = 8'hEE;
        checks++; if (to !== 1'b0 || is_rd !== 1'b0 || a !== 3'd0 || d !== 8'h81) begin errors++; $display("FAIL rx_ack: got to=%b rd=%b addr=%0d data=%h expected 0/0/0/81", to, is_rd, a, d); end
        @(negedge clock);
        checks++; if (rx_valid !== 1'b1 || rx_byte !== 8'h3C) begin errors++; $display("FAIL rx_byte: got valid=%b byte=%h expected 1/3c", rx_valid, rx_byte); end
        pop_one(v, b);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_pop: got valid=%b expected 0", rx_valid); end
    endtask

    task automatic test_overrun();
        logic is_rd; logic [2:0] a; logic [7:0] d; logic to; logic v; logic [7:0] b;
        int rc0;
        rx_ready = 1'b0;
        for (int i = 0; i < RX_CAP; i++) begin
            bus.out_data = 8'h10 + 8'(i); bus.irq_id = IRQ_RX_AVAIL; bus.irq = 1'b1;
            wait_strobe(is_rd, a, d, to);
            checks++; if (to !== 1'b0 || is_rd !== 1'b1) begin errors++; $display("FAIL fill_read_%0d: got to=%b rd=%b expected 0/1", i, to, is_rd); end
            wait_strobe(is_rd, a, d, to);
            bus.irq = 1'b0;
            @(negedge clock);
        end
        checks++; if (rx_overrun !== 1'b0 || rx_valid !== 1'b1) begin errors++; $display("FAIL fill_state: got ovr=%b valid=%b expected 0/1", rx_overrun, rx_valid); end
        rc0 = rd_count;
        bus.out_data = 8'h50; bus.irq_id = IRQ_RX_AVAIL; bus.irq = 1'b1;
        repeat (6) @(negedge clock);
        checks++; if (rd_count !== rc0) begin errors++; $display("FAIL full_no_read: got %0d reads expected 0", rd_count - rc0); end
        checks++; if (rx_overrun !== 1'b1 || tx_ready !== 1'b0) begin errors++; $display("FAIL overrun_flag: got ovr=%b tx_ready=%b expected 1/0", rx_overrun, tx_ready); end
        pop_one(v, b);
        checks++; if (v !== 1'b1 || b !== 8'h10) begin errors++; $display("FAIL drain_first: got %b/%h expected 1/10", v, b); end
        wait_strobe(is_rd, a, d, to);
        checks++; if (to !== 1'b0 || is_rd !== 1'b1 || a !== 3'd1) begin errors++; $display("FAIL resume_read: got to=%b rd=%b addr=%0d expected 0/1/1", to, is_rd, a); end
        wait_strobe(is_rd, a, d, to);
        bus.irq = 1'b0;
        checks++; if (to !== 1'b0 || d !== 8'h81) begin errors++; $display("FAIL resume_ack: got to=%b data=%h expected 0/81", to, d); end
        repeat (2) @(negedge clock);
        for (int i = 1; i < RX_CAP; i++) begin
            pop_one(v, b);
            checks++; if (v !== 1'b1 || b !== 8'h10 + 8'(i)) begin errors++; $display("FAIL drain_%0d: got %b/%h expected 1/%h", i, v, b, 8'h10 + 8'(i)); end
        end
        pop_one(v, b);
        checks++; if (v !== 1'b1 || b !== 8'h50) begin errors++; $display("FAIL drain_last: got %b/%h expected 1/50", v, b); end
        checks++; if (rx_valid !== 1'b0 || rx_overrun !== 1'b1) begin errors++; $display("FAIL drain_end: got valid=%b ovr=%b expected 0/1", rx_valid, rx_overrun); end
    endtask

    task automatic test_priority();
        logic is_rd; logic [2:0] a; logic [7:0] d; logic to; logic v; logic [7:0] b;
        bus.out_data = 8'h77; bus.irq_id = IRQ_RX_AVAIL; bus.irq = 1'b1;
        tx_byte = 8'h5A; tx_valid = 1'b1;
        wait_strobe(is_rd, a, d, to);
        checks++; if (to !== 1'b0 || is_rd !== 1'b1 || a !== 3'd1) begin errors++; $display("FAIL prio_first: got to=%b rd=%b addr=%0d expected 0/1/1", to, is_rd, a); end
        wait_strobe(is_rd, a, d, to);
        bus.irq = 1'b0;
        checks++; if (to !== 1'b0 || a !== 3'd0 || d !== 8'h81) begin errors++; $display("FAIL prio_ack: got to=%b addr=%0d data=%h expected 0/0/81", to, a, d); end
        wait_strobe(is_rd, a, d, to);
        tx_valid = 1'b0;
        checks++; if (to !== 1'b0 || is_rd !== 1'b0 || a !== 3'd2 || d !== 8'h5A) begin errors++; $display("FAIL prio_tx: got to=%b rd=%b addr=%0d data=%h expected 0/0/2/5a", to, is_rd, a, d); end
        repeat (2) @(negedge clock);
        pop_one(v, b);
        checks++; if (v !== 1'b1 || b !== 8'h77) begin errors++; $display("FAIL prio_rx_byte: got %b/%h expected 1/77", v, b); end
        bus.irq_id = IRQ_TX_DONE; bus.irq = 1'b1;
        wait_strobe(is_rd, a, d, to);
        bus.irq = 1'b0;
        checks++; if (to !== 1'b0 || d !== 8'h82) begin errors++; $display("FAIL prio_done_ack: got to=%b data=%h expected 0/82", to, d); end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset_mid();
        logic is_rd; logic [2:0] a; logic [7:0] d; logic to;
        bus.out_data = 8'h99; bus.irq_id = IRQ_RX_AVAIL; bus.irq = 1'b1;
        wait_strobe(is_rd, a, d, to);
        wait_strobe(is_rd, a, d, to);
        bus.irq = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", rx_valid); end
        tx_byte = 8'h33; tx_valid = 1'b1;
        wait_strobe(is_rd, a, d, to);
        tx_valid = 1'b0;
        checks++; if (to !== 1'b0 || bus.wr !== 1'b0) begin errors++; $display("FAIL mid_in_strobe: got to=%b wr=%b expected 0/0", to, bus.wr); end
        #1 reset = 1'b0;
        #1;
        checks++; if (bus.cs !== 1'b1 || bus.rd !== 1'b1 || bus.wr !== 1'b1) begin errors++; $display("FAIL mid_strobes: got cs=%b rd=%b wr=%b expected 1/1/1", bus.cs, bus.rd, bus.wr); end
        checks++; if (bus.addr !== 3'd0 || bus.in_data !== 8'd0) begin errors++; $display("FAIL mid_addr_data: got %0d/%h expected 0/00", bus.addr, bus.in_data); end
        checks++; if (rx_valid !== 1'b0 || rx_overrun !== 1'b0 || tx_ready !== 1'b0) begin errors++; $display("FAIL mid_flags: got valid=%b ovr=%b rdy=%b expected 0/0/0", rx_valid, rx_overrun, tx_ready); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if (tx_ready !== 1'b1 || bus.cs !== 1'b1 || rx_valid !== 1'b0) begin errors++; $display("FAIL mid_after: got rdy=%b cs=%b valid=%b expected 1/1/0", tx_ready, bus.cs, rx_valid); end
    endtask

    task automatic test_strobe_exclusive();
        checks++; if (both_low !== 1'b0) begin errors++; $display("FAIL strobe_exclusive: got both_low=%b expected 0", both_low); end
    endtask

    initial begin
        test_reset();
        test_tx_write();
        test_rx_read();
        test_overrun();
        test_priority();
        test_reset_mid();
        test_strobe_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
